// File: rtl/block_checker_nd.sv
// Streaming "begin"/"end" nesting checker with tentative depth update, sticky over/underflow error.
// Latency: 1 cycle from accepting edge to depth/err/result; no backpressure, every valid beat is consumed.
module block_checker_nd #(
    parameter int MAX_DEPTH = 15,
    parameter int DEPTH_W   = 4,
    parameter int WS_EXT    = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [7:0]         in,
    output logic [DEPTH_W-1:0] depth,
    output logic               err,
    output logic               result
);

    if (MAX_DEPTH < 1 || MAX_DEPTH > (1 << DEPTH_W) - 1) begin : g_bad_max_depth
        $error("block_checker_nd: MAX_DEPTH must lie in 1..2^DEPTH_W-1");
    end

    localparam logic [DEPTH_W-1:0] MAX_D = DEPTH_W'(MAX_DEPTH);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        B1   = 4'd1,
        B2   = 4'd2,
        B3   = 4'd3,
        B4   = 4'd4,
        BN   = 4'd5,
        E1   = 4'd6,
        E2   = 4'd7,
        EN   = 4'd8,
        SKIP = 4'd9
    } state_t;

    state_t             state_q, state_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               err_q, err_d;
    logic               pend_up_q, pend_up_d;
    logic               pend_dn_q, pend_dn_d;
    logic               pend_err_q, pend_err_d;

    logic       is_delim;
    logic [7:0] lc;
    logic       go_inc, go_dec, commit, revert;

    // Folding bit 5 lowercases letters; delimiters are tested on the raw byte.
    assign lc = in | 8'h20;

    always_comb begin
        is_delim = (in == 8'h20);
        if (WS_EXT != 0) begin
            is_delim = is_delim || (in == 8'h09) || (in == 8'h0A) || (in == 8'h0D);
        end
    end

    always_comb begin
        state_d = state_q;
        go_inc  = 1'b0;
        go_dec  = 1'b0;
        commit  = 1'b0;
        revert  = 1'b0;
        if (in_valid) begin
            if (is_delim) begin
                state_d = IDLE;
                commit  = (state_q == BN) || (state_q == EN);
            end else begin
                state_d = SKIP;
                case (state_q)
                    IDLE: begin
                        if (lc == "b")      state_d = B1;
                        else if (lc == "e") state_d = E1;
                    end
                    B1: if (lc == "e") state_d = B2;
                    B2: if (lc == "g") state_d = B3;
                    B3: if (lc == "i") state_d = B4;
                    B4: begin
                        if (lc == "n") begin
                            state_d = BN;
                            go_inc  = 1'b1;
                        end
                    end
                    E1: if (lc == "n") state_d = E2;
                    E2: begin
                        if (lc == "d") begin
                            state_d = EN;
                            go_dec  = 1'b1;
                        end
                    end
                    BN, EN:  revert = 1'b1;
                    default: state_d = SKIP;
                endcase
            end
        end
    end

    // Depth and pending flags; all frozen once the sticky error is set.
    always_comb begin
        depth_d    = depth_q;
        err_d      = err_q;
        pend_up_d  = pend_up_q;
        pend_dn_d  = pend_dn_q;
        pend_err_d = pend_err_q;
        if (!err_q) begin
            if (go_inc) begin
                if (depth_q < MAX_D) begin
                    depth_d   = depth_q + 1'b1;
                    pend_up_d = 1'b1;
                end else begin
                    pend_err_d = 1'b1;
                end
            end
            if (go_dec) begin
                if (depth_q != '0) begin
                    depth_d   = depth_q - 1'b1;
                    pend_dn_d = 1'b1;
                end else begin
                    pend_err_d = 1'b1;
                end
            end
            if (commit) begin
                pend_up_d  = 1'b0;
                pend_dn_d  = 1'b0;
                pend_err_d = 1'b0;
                if (pend_err_q) err_d = 1'b1;
            end
            if (revert) begin
                if (pend_up_q)      depth_d = depth_q - 1'b1;
                else if (pend_dn_q) depth_d = depth_q + 1'b1;
                pend_up_d  = 1'b0;
                pend_dn_d  = 1'b0;
                pend_err_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            depth_q    <= '0;
            err_q      <= 1'b0;
            pend_up_q  <= 1'b0;
            pend_dn_q  <= 1'b0;
            pend_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            depth_q    <= depth_d;
            err_q      <= err_d;
            pend_up_q  <= pend_up_d;
            pend_dn_q  <= pend_dn_d;
            pend_err_q <= pend_err_d;
        end
    end

    assign depth  = depth_q;
    assign err    = err_q;
    assign result = (depth_q == '0) && !err_q && !pend_err_q;

endmodule

// File: doc/block_checker_nd.md
Name: block_checker_nd

Overview:
- Streaming keyword-nesting checker: consumes one ASCII character per accepted beat and tracks nesting of the case-insensitive words "begin" / "end".
- Generalises the single-level checker with:
  - a parametrised depth counter,
  - an input valid qualifier,
  - overflow/underflow detection with a sticky error,
  - a configurable delimiter set.
- Sits after the character source (UART RX / testbench stream); result feeds the status/LED logic.

Parameters:
- MAX_DEPTH, 15, maximum legal nesting depth (1..2^DEPTH_W-1).
- DEPTH_W, 4, width of the depth counter and depth output.
- WS_EXT, 0, 0: only space (0x20) delimits words; 1: space, tab (0x09), LF (0x0A) and CR (0x0D) all delimit.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-low reset
- in_valid  input  1  character on in is consumed this cycle when 1
- in  input  8  ASCII character
- depth  output  DEPTH_W  current nesting depth, including a tentative update
- err  output  1  sticky error: committed overflow or underflow
- result  output  1  1 when depth==0, err==0 and no tentative error pending

Behaviour:
- Reset: sampled on the clk edge when reset==0. Sets depth=0, err=0, pend_up=pend_dn=pend_err=0, FSM=IDLE, so result=1. Reset overrides in_valid and may occur mid-word; the partial word is discarded.
- in_valid==0: no state change of any kind.
- Delimiter: a character is a delimiter per WS_EXT. Letter compare is case-insensitive (upper or lower accepted).
- FSM states and transitions (all on accepted beats only):
  - IDLE:
    - b/B -> B1
    - e/E -> E1
    - delimiter -> IDLE
    - other -> SKIP
  - B1..B4: expect e, g, i, n in turn.
    - match -> next state
    - delimiter -> IDLE
    - other -> SKIP
    - At B4 on n/N -> BN with a tentative increment.
  - BN (word "begin" seen):
    - delimiter -> IDLE, commit
    - other -> SKIP, revert
  - E1: n/N -> E2; delimiter -> IDLE; other -> SKIP.
  - E2: d/D -> EN with a tentative decrement; delimiter -> IDLE; other -> SKIP.
  - EN (word "end" seen):
    - delimiter -> IDLE, commit
    - other -> SKIP, revert
  - SKIP: delimiter -> IDLE; otherwise stay.
- Tentative increment (entering BN):
  - If depth<MAX_DEPTH: depth+1 immediately (same edge), pend_up=1.
  - Else: depth unchanged, pend_err=1.
- Tentative decrement (entering EN):
  - If depth>0: depth-1 immediately, pend_dn=1.
  - Else: depth unchanged, pend_err=1.
- Commit (delimiter in BN/EN): clear pend_up/pend_dn. If pend_err, set err=1 and clear pend_err.
- Revert (non-delimiter in BN/EN): undo the tentative change (depth-1 if pend_up, depth+1 if pend_dn) and clear all pend flags. Example: "beginx" and "ends" leave depth unchanged.
- Sticky error: once err=1, it and depth freeze until reset. The FSM keeps parsing, but no depth updates or pend flags are applied. Text after an unmatched "end" therefore never restores result.
- End of stream: no commit is required. A trailing "begin" / "end" with no delimiter keeps its tentative value visible on depth/result.
- Result and latency:
  - result = (depth==0) && !err && !pend_err, combinational from registers.
  - depth, err and result reflect a character one cycle after its accepting edge; there is no other latency.
- Width: depth never wraps. Saturation is guaranteed by the MAX_DEPTH/underflow checks. Assertion: MAX_DEPTH <= 2^DEPTH_W-1.

Test Plan:
- "BeGiN x eNd " all valid -> depth 1 after the n beat, result=0; depth 0 after the d beat; result=1 at end, err=0.
- "beginner end" -> depth 1 after "begin", back to 0 on 'n' (revert); the "end" then triggers underflow: pend_err, result=0; err=1 after the trailing space; depth stays 0, result stays 0 afterwards even after "begin end ".
- MAX_DEPTH=2: "begin begin begin " -> depth 2, third word sets pend_err, err=1 on the space, depth frozen at 2; a later "end end " leaves depth=2, err=1.
- WS_EXT=1: "begin\tend\n" -> depth 1 then 0, result=1. With WS_EXT=0 the same stream -> tab is not a delimiter, "begin\t" reverts, "end\n" skipped, depth 0, result=1, err=0.
- in_valid toggled 0 between each char of "begin " (with in=garbage while invalid) -> identical to the contiguous case, depth=1.
- reset=0 for one cycle mid-"begi" with depth=3 -> next cycle depth=0, err=0, result=1, FSM IDLE; following "end " sets err=1.
